// File: rtl/counter_seq_pkg.sv
// Shared definitions for the counter sequencer: command encodings, FSM states,
// default sizing and the prescaler width helper.
package counter_seq_pkg;

  localparam int unsigned DEF_WIDTH = 4;
  localparam int unsigned DEF_DIV   = 1;

  localparam logic [1:0] OP_RUN    = 2'b00;
  localparam logic [1:0] OP_PAUSE  = 2'b01;
  localparam logic [1:0] OP_RESUME = 2'b10;
  localparam logic [1:0] OP_CLEAR  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSED,
    S_DONE
  } state_e;

  // A divide-by-one prescaler still needs a 1-bit register to stay legal.
  function automatic int unsigned presc_width(input int unsigned div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/en_counter.sv
// WIDTH-bit synchronous counter with enable and synchronous clear, flagging
// when the next increment lands on the target and when it is at all-ones.
module en_counter
  import counter_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_target,
  output logic [WIDTH-1:0] o_count,
  output logic             o_hit,
  output logic             o_all_ones
);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_next;

  assign w_next     = r_count + WIDTH'(1);
  assign o_count    = r_count;
  assign o_hit      = (w_next == i_target);
  assign o_all_ones = &r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= w_next;
    end
  end

endmodule

// File: rtl/counter_sequencer.sv
// Command-driven run/pause/resume/clear sequencer around en_counter, with a
// clock-enable prescaler and one-cycle done/wrap pulses.
module counter_sequencer
  import counter_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DIV   = DEF_DIV
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_target,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             paused,
  output logic             done,
  output logic             wrap
);

  localparam int unsigned   PW        = presc_width(DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

  state_e           r_state, w_state_nxt;
  logic [PW-1:0]    r_presc;
  logic [WIDTH-1:0] r_target;
  logic             r_done, r_wrap;

  logic w_acc, w_cnt_en, w_cnt_clr, w_presc_clr, w_presc_inc;
  logic w_load, w_done_nxt, w_wrap_nxt, w_hit, w_all_ones;

  assign cmd_ready = (r_state != S_DONE);
  assign w_acc     = cmd_valid && cmd_ready;
  assign busy      = (r_state == S_RUN) || (r_state == S_PAUSED);
  assign paused    = (r_state == S_PAUSED);
  assign done      = r_done;
  assign wrap      = r_wrap;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_en    = 1'b0;
    w_cnt_clr   = 1'b0;
    w_presc_clr = 1'b0;
    w_presc_inc = 1'b0;
    w_load      = 1'b0;
    w_done_nxt  = 1'b0;
    w_wrap_nxt  = 1'b0;
    // An accepted command pre-empts any counting step in the same cycle.
    if (w_acc) begin
      case (cmd_op)
        OP_RUN: begin
          w_load      = 1'b1;
          w_cnt_clr   = 1'b1;
          w_presc_clr = 1'b1;
          w_state_nxt = S_RUN;
        end
        OP_PAUSE:  if (r_state == S_RUN)    w_state_nxt = S_PAUSED;
        OP_RESUME: if (r_state == S_PAUSED) w_state_nxt = S_RUN;
        default: begin
          w_cnt_clr   = 1'b1;
          w_presc_clr = 1'b1;
          w_state_nxt = S_IDLE;
        end
      endcase
    end else begin
      case (r_state)
        S_RUN: begin
          if (r_presc == PRESC_MAX) begin
            w_presc_clr = 1'b1;
            w_cnt_en    = 1'b1;
            if (r_target != '0) begin
              if (w_hit) begin
                w_done_nxt  = 1'b1;
                w_state_nxt = S_DONE;
              end
            end else begin
              w_wrap_nxt = w_all_ones;
            end
          end else begin
            w_presc_inc = 1'b1;
          end
        end
        S_DONE:  w_state_nxt = S_IDLE;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_presc  <= '0;
      r_target <= '0;
      r_done   <= 1'b0;
      r_wrap   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_presc_clr) begin
        r_presc <= '0;
      end else if (w_presc_inc) begin
        r_presc <= r_presc + PW'(1);
      end
      if (w_load) begin
        r_target <= cmd_target;
      end
      r_done <= w_done_nxt;
      r_wrap <= w_wrap_nxt;
    end
  end

  en_counter #(
    .WIDTH(WIDTH)
  ) u_cnt (
    .clk       (clk),
    .reset     (reset),
    .i_en      (w_cnt_en),
    .i_clr     (w_cnt_clr),
    .i_target  (r_target),
    .o_count   (count),
    .o_hit     (w_hit),
    .o_all_ones(w_all_ones)
  );

endmodule
